// File: rtl/uart_pkg.sv
// Shared UART transmit definitions: parity modes, length codes, FSM encoding.
package uart_pkg;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  localparam logic [1:0] LEN_5 = 2'b00;
  localparam logic [1:0] LEN_6 = 2'b01;
  localparam logic [1:0] LEN_7 = 2'b10;
  localparam logic [1:0] LEN_8 = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP1  = 3'd4,
    ST_STOP2  = 3'd5
  } tx_state_e;

  // Length code to number of data bits (5..8).
  function automatic logic [3:0] len_bits(input logic [1:0] code);
    return 4'(code) + 4'd5;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with registered full/empty/count and first-word-fall-through read data.
module uart_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count_d;

  assign count_d = count + CW'(push) - CW'(pop);
  assign rdata   = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_d;
      full  <= (count_d == CW'(DEPTH));
      empty <= (count_d == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter with write FIFO, runtime divisor, 5-8 data bits, optional parity, 1/2 stop bits.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned MAX_DATA_BITS = 8,
  parameter int unsigned FIFO_DEPTH    = 8,
  parameter int unsigned DIV_WIDTH     = 16
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [DIV_WIDTH-1:0]          i_Divisor,
  input  logic [1:0]                    i_Datalength,
  input  logic [1:0]                    i_ParityMode,
  input  logic                          i_StopBits,
  input  logic [MAX_DATA_BITS-1:0]      i_Data,
  input  logic                          i_WriteEnable,
  output logic                          o_DataOut,
  output logic                          o_Busy,
  output logic                          o_Full,
  output logic                          o_Empty,
  output logic [$clog2(FIFO_DEPTH):0]   o_Count,
  output logic                          o_Overflow
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  logic                     fifo_push;
  logic                     fifo_pop;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic [MAX_DATA_BITS-1:0] fifo_rdata;
  logic [CW-1:0]            fifo_count;
  logic [CW-1:0]            count_nxt;

  tx_state_e                state_q, state_d;
  logic [DIV_WIDTH-1:0]     div_q, div_d;
  logic [DIV_WIDTH-1:0]     div_cnt_q, div_cnt_d;
  logic [2:0]               bit_cnt_q, bit_cnt_d;
  logic [MAX_DATA_BITS-1:0] shreg_q, shreg_d;
  logic                     par_en_q, par_en_d;
  logic                     par_bit_q, par_bit_d;
  logic                     stop2_q, stop2_d;
  logic                     line_q, line_d;
  logic                     busy_q, busy_d;
  logic                     ovf_q, ovf_d;

  logic                     bit_done;
  logic                     last_stop;
  logic [3:0]               cfg_nbits;
  logic [MAX_DATA_BITS-1:0] data_masked;

  uart_sync_fifo #(
    .WIDTH (MAX_DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clock),
    .rst   (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (i_Data),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a write then.
  assign bit_done  = (div_cnt_q == '0);
  assign last_stop = bit_done &&
                     ((state_q == ST_STOP2) || ((state_q == ST_STOP1) && !stop2_q));
  assign fifo_pop  = !fifo_empty && ((state_q == ST_IDLE) || last_stop);
  assign fifo_push = i_WriteEnable && (!fifo_full || fifo_pop);
  assign count_nxt = fifo_count + CW'(fifo_push) - CW'(fifo_pop);

  assign cfg_nbits = (len_bits(i_Datalength) > 4'(MAX_DATA_BITS)) ?
                     4'(MAX_DATA_BITS) : len_bits(i_Datalength);

  // Zero the bits beyond the configured length so they never reach parity or the line.
  always_comb begin
    data_masked = '0;
    for (int unsigned i = 0; i < MAX_DATA_BITS; i++) begin
      if (4'(i) < cfg_nbits) data_masked[i] = fifo_rdata[i];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      div_q     <= '0;
      div_cnt_q <= '0;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      stop2_q   <= 1'b0;
      line_q    <= 1'b1;
      busy_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      div_cnt_q <= div_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
      stop2_q   <= stop2_d;
      line_q    <= line_d;
      busy_q    <= busy_d;
      ovf_q     <= ovf_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    div_cnt_d = div_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
    stop2_d   = stop2_q;
    line_d    = line_q;

    if (state_q != ST_IDLE) begin
      div_cnt_d = bit_done ? div_q : div_cnt_q - DIV_WIDTH'(1);
    end

    unique case (state_q)
      ST_IDLE: line_d = 1'b1;
      ST_START: begin
        if (bit_done) begin
          state_d = ST_DATA;
          line_d  = shreg_q[0];
        end
      end
      ST_DATA: begin
        if (bit_done) begin
          if (bit_cnt_q == '0) begin
            if (par_en_q) begin
              state_d = ST_PARITY;
              line_d  = par_bit_q;
            end else begin
              state_d = ST_STOP1;
              line_d  = 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q - 3'd1;
            shreg_d   = shreg_q >> 1;
            line_d    = shreg_q[1];
          end
        end
      end
      ST_PARITY: begin
        if (bit_done) begin
          state_d = ST_STOP1;
          line_d  = 1'b1;
        end
      end
      ST_STOP1: begin
        if (bit_done) begin
          state_d = stop2_q ? ST_STOP2 : ST_IDLE;
          line_d  = 1'b1;
        end
      end
      ST_STOP2: begin
        if (bit_done) begin
          state_d = ST_IDLE;
          line_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        line_d  = 1'b1;
      end
    endcase

    // Pop latches the whole frame config; later input changes wait for the next frame.
    if (fifo_pop) begin
      state_d   = ST_START;
      line_d    = 1'b0;
      div_d     = i_Divisor;
      div_cnt_d = i_Divisor;
      bit_cnt_d = 3'(cfg_nbits - 4'd1);
      shreg_d   = data_masked;
      par_en_d  = (i_ParityMode == PAR_EVEN) || (i_ParityMode == PAR_ODD);
      par_bit_d = (i_ParityMode == PAR_ODD) ? ~(^data_masked) : (^data_masked);
      stop2_d   = i_StopBits;
    end

    busy_d = (state_d != ST_IDLE) || (count_nxt != '0);
    ovf_d  = i_WriteEnable && !fifo_push;
  end

  assign o_DataOut  = line_q;
  assign o_Busy     = busy_q;
  assign o_Full     = fifo_full;
  assign o_Empty    = fifo_empty;
  assign o_Count    = fifo_count;
  assign o_Overflow = ovf_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo against a queue-based frame model.
module tb_uart_tx_fifo;

  localparam int unsigned MAX_DATA_BITS = 8;
  localparam int unsigned DEPTH         = 8;
  localparam int unsigned DIV_WIDTH     = 16;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] i_Divisor;
  logic [1:0]  i_Datalength;
  logic [1:0]  i_ParityMode;
  logic        i_StopBits;
  logic [7:0]  i_Data;
  logic        i_WriteEnable;
  logic        o_DataOut;
  logic        o_Busy;
  logic        o_Full;
  logic        o_Empty;
  logic [3:0]  o_Count;
  logic        o_Overflow;

  uart_tx_fifo #(
    .MAX_DATA_BITS (MAX_DATA_BITS),
    .FIFO_DEPTH    (DEPTH),
    .DIV_WIDTH     (DIV_WIDTH)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .i_Divisor     (i_Divisor),
    .i_Datalength  (i_Datalength),
    .i_ParityMode  (i_ParityMode),
    .i_StopBits    (i_StopBits),
    .i_Data        (i_Data),
    .i_WriteEnable (i_WriteEnable),
    .o_DataOut     (o_DataOut),
    .o_Busy        (o_Busy),
    .o_Full        (o_Full),
    .o_Empty       (o_Empty),
    .o_Count       (o_Count),
    .o_Overflow    (o_Overflow)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;
  int n_ovf_seen;
  int full_seen;

  // Model: FIFO contents plus the remaining per-clock line levels of the current frame.
  logic [7:0] mq[$];
  logic       pend[$];
  logic       m_line;
  logic       m_inframe;
  logic       m_ovf;
  logic       m_busy;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic push_bit(input logic b, input int reps);
    for (int k = 0; k < reps; k++) pend.push_back(b);
  endtask

  task automatic build_frame(input logic [7:0] d);
    int   nb;
    int   reps;
    logic p;
    nb = int'(i_Datalength) + 5;
    if (nb > int'(MAX_DATA_BITS)) nb = int'(MAX_DATA_BITS);
    reps = int'(i_Divisor) + 1;
    p = 1'b0;
    push_bit(1'b0, reps);
    for (int i = 0; i < nb; i++) begin
      push_bit(d[i], reps);
      p = p ^ d[i];
    end
    if (i_ParityMode == 2'b01) push_bit(p, reps);
    else if (i_ParityMode == 2'b10) push_bit(~p, reps);
    push_bit(1'b1, reps);
    if (i_StopBits) push_bit(1'b1, reps);
  endtask

  task automatic model_reset();
    mq.delete();
    pend.delete();
    m_line = 1'b1; m_inframe = 1'b0; m_ovf = 1'b0; m_busy = 1'b0;
  endtask

  task automatic model_edge(input logic wr, input logic [7:0] d);
    logic pop;
    logic acc;
    pop = (pend.size() == 0) && (mq.size() > 0);
    acc = wr && ((mq.size() < DEPTH) || pop);
    m_ovf = wr && !acc;
    if (pop) build_frame(mq.pop_front());
    if (acc) mq.push_back(d);
    if (pend.size() > 0) begin
      m_line = pend.pop_front();
      m_inframe = 1'b1;
    end else begin
      m_line = 1'b1;
      m_inframe = 1'b0;
    end
    m_busy = m_inframe || (mq.size() > 0);
  endtask

  task automatic check_outputs(input string pfx);
    chk({pfx, "_line"},  32'(o_DataOut),  32'(m_line));
    chk({pfx, "_busy"},  32'(o_Busy),     32'(m_busy));
    chk({pfx, "_count"}, 32'(o_Count),    32'(mq.size()));
    chk({pfx, "_full"},  32'(o_Full),     32'(mq.size() == DEPTH));
    chk({pfx, "_empty"}, 32'(o_Empty),    32'(mq.size() == 0));
    chk({pfx, "_ovf"},   32'(o_Overflow), 32'(m_ovf));
    if (o_Overflow) n_ovf_seen++;
    if (o_Full) full_seen = 1;
  endtask

  task automatic tick(input logic wr, input logic [7:0] d);
    i_WriteEnable = wr;
    i_Data = d;
    if (reset) model_reset();
    else model_edge(wr, d);
    @(posedge clock);
    #1;
    check_outputs("cyc");
    i_WriteEnable = 1'b0;
  endtask

  task automatic set_cfg(input logic [15:0] dv, input logic [1:0] len,
                         input logic [1:0] par, input logic stp);
    i_Divisor = dv; i_Datalength = len; i_ParityMode = par; i_StopBits = stp;
  endtask

  // Bounded by the model, which always finishes its queued frames.
  task automatic drain(input int budget);
    for (int i = 0; i < budget && m_busy; i++) tick(1'b0, 8'h00);
    tick(1'b0, 8'h00);
    chk("drain_busy", 32'(o_Busy), 32'(0));
  endtask

  initial begin
    reset = 1'b1;
    i_WriteEnable = 1'b0;
    i_Data = 8'h00;
    set_cfg(16'd3, 2'b11, 2'b00, 1'b0);
    model_reset();
    n_ovf_seen = 0;
    full_seen = 0;
    #1;
    check_outputs("rst");
    tick(1'b0, 8'h00);
    tick(1'b0, 8'h00);
    reset = 1'b0;
    tick(1'b0, 8'h00);

    // 8N1, divisor 3, single byte
    set_cfg(16'd3, 2'b11, 2'b00, 1'b0);
    tick(1'b1, 8'h55);
    drain(100);

    // 7E2, divisor 1
    set_cfg(16'd1, 2'b10, 2'b01, 1'b1);
    tick(1'b1, 8'h53);
    drain(100);

    // 5O1, divisor 0, upper bits ignored
    set_cfg(16'd0, 2'b00, 2'b10, 1'b0);
    tick(1'b1, 8'hFF);
    drain(100);

    // Fill past capacity: one drop, back-to-back frames
    set_cfg(16'd3, 2'b11, 2'b00, 1'b0);
    n_ovf_seen = 0;
    full_seen = 0;
    for (int i = 0; i < 10; i++) tick(1'b1, 8'(8'h50 + i));
    drain(1000);
    chk("t4_ovf_pulses", 32'(n_ovf_seen), 32'(1));
    chk("t4_full_seen", 32'(full_seen), 32'(1));

    // Divisor change mid-frame applies to the next frame only
    set_cfg(16'd7, 2'b11, 2'b00, 1'b0);
    tick(1'b1, 8'hA5);
    for (int i = 0; i < 20; i++) tick(1'b0, 8'h00);
    i_Divisor = 16'd1;
    tick(1'b1, 8'h3C);
    drain(200);

    // Reset during DATA with entries queued
    set_cfg(16'd3, 2'b11, 2'b00, 1'b0);
    for (int i = 0; i < 4; i++) tick(1'b1, 8'(8'hC0 + i));
    for (int i = 0; i < 10; i++) tick(1'b0, 8'h00);
    reset = 1'b1;
    #1;
    model_reset();
    check_outputs("mid_rst");
    tick(1'b0, 8'h00);
    reset = 1'b0;
    for (int i = 0; i < 60; i++) tick(1'b0, 8'h00);

    // Randomized traffic with varying write pressure and config churn
    for (int seg = 0; seg < 4; seg++) begin
      int wp;
      wp = 10 + seg * 25;
      for (int i = 0; i < 800; i++) begin
        if ($urandom_range(0, 99) < 5)
          set_cfg(16'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                  2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        tick(1'($urandom_range(0, 99) < wp), 8'($urandom_range(0, 255)));
      end
      drain(2000);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Parametrised UART transmitter; next generation of the single-byte tx generator used by the project_top benches.
- Adds a write FIFO, a runtime baud divisor, 5–8 bit data length, none/even/odd parity, and 1 or 2 stop bits.
- Serves as the host-side serial source in benches and as the transmit path under project_top.

Parameters:
MAX_DATA_BITS, 8, width of i_Data; legal values 5..8
FIFO_DEPTH, 8, FIFO entries; power of two, >=2
DIV_WIDTH, 16, width of i_Divisor

Ports:
clock  in  1  single system clock; all logic on its rising edge
reset  in  1  asynchronous, active-high; clears FIFO, FSM and all outputs
i_Divisor  in  DIV_WIDTH  bit period is i_Divisor+1 clocks
i_Datalength  in  2  00=5, 01=6, 10=7, 11=8 data bits; clamped to MAX_DATA_BITS
i_ParityMode  in  2  00=none, 01=even, 10=odd, 11=none
i_StopBits  in  1  0=one stop bit, 1=two stop bits
i_Data  in  MAX_DATA_BITS  byte to enqueue; bits above the configured length are ignored
i_WriteEnable  in  1  one-cycle write strobe
o_DataOut  out  1  serial line; idles high
o_Busy  out  1  high while a frame is in progress or the FIFO is non-empty
o_Full  out  1  FIFO count == FIFO_DEPTH
o_Empty  out  1  FIFO count == 0
o_Count  out  clog2(FIFO_DEPTH)+1  FIFO occupancy
o_Overflow  out  1  one-cycle pulse when a write is dropped

Behaviour:
- Reset values (asynchronous): o_DataOut=1, o_Busy=0, o_Full=0, o_Empty=1, o_Count=0, o_Overflow=0, FSM=IDLE, FIFO pointers=0.
- Write accept:
  - A write is accepted if i_WriteEnable=1 and either count<DEPTH, or a pop occurs in the same cycle. A simultaneous write and pop when full is accepted and count is unchanged.
  - Otherwise the write is dropped and o_Overflow=1 for the next cycle only.
- Pop: occurs in any cycle where the FSM is IDLE and the FIFO is non-empty, or in the last clock of the final stop bit with the FIFO non-empty.
- Frame config latch: at pop, latch data, i_Divisor, i_Datalength, i_ParityMode and i_StopBits. Config changes mid-frame take effect only at the next frame.
- FSM states: IDLE -> START -> DATA -> (PARITY if mode even/odd) -> STOP1 -> (STOP2 if i_StopBits=1) -> IDLE, or directly to START if a pop occurs at the end of the final stop bit.
- Each state drives o_DataOut for exactly divisor+1 clocks, counted by a DIV_WIDTH down-counter. Divisor=0 gives one clock per bit.
- DATA sends bits LSB first, for the latched length.
- Parity bit:
  - even: XOR of the transmitted data bits.
  - odd: inverted XOR of the transmitted data bits.
- Line levels: START=0, STOP=1, IDLE=1.
- Latency: with a write at edge N into an empty FIFO and IDLE FSM, the pop occurs at edge N+1 and o_DataOut falls at edge N+1 (registered output). The start bit therefore begins one cycle after the write.
- Back-to-back frames have no idle gap: the next start bit immediately follows the final stop bit.
- o_Busy falls on the edge that ends the final stop bit of the last queued frame.
- o_Count, o_Full and o_Empty are registered and reflect the state after each edge.
- Reset mid-frame: the line returns high immediately and queued data is discarded.
- The pointers wrap modulo FIFO_DEPTH. The count needs the extra bit to distinguish full from empty.

Decomposition:
- Shared package uart_pkg holds:
  - parity mode constants (PAR_NONE, PAR_EVEN, PAR_ODD)
  - length codes (LEN_5..LEN_8)
  - FSM state encoding
  - a function mapping a length code to a bit count
- One sub-module, uart_sync_fifo: parametrised on width and depth, with push/pop/full/empty/count outputs and first-word data out.
- The FSM, divider and shifter stay in uart_tx_fifo.

Test Plan:
- Divisor=3, 8N1, write 0x55 once -> o_DataOut low from edge after write for 4 clocks, then 1,0,1,0,1,0,1,0 at 4 clocks each, then high 4 clocks; total 40 clocks; o_Busy then 0.
- Divisor=1, 7 bits, even parity, 2 stop, write 0x53 -> data 1,1,0,0,1,0,1; parity 0; two stop bits; 11 bits x 2 clocks = 22 clocks.
- Divisor=0, 5 bits, odd parity, 1 stop, write 0xFF -> data 1,1,1,1,1; parity 0; frame is 8 clocks; bits 7..5 of i_Data are ignored.
- Divisor=3, 8N1, DEPTH=8, write 0x50..0x59 on 10 consecutive cycles -> o_Full after the 9th write, o_Overflow pulses once, 0x59 is dropped; 0x50..0x58 are transmitted back-to-back with no high gap between frames (9x40 clocks).
- Start 0xA5 with divisor=7; change i_Divisor to 1 mid-frame; queue 0x3C -> 0xA5 completes at 8 clocks/bit, 0x3C goes out at 2 clocks/bit.
- Assert reset during the DATA bits of a frame with 3 entries queued -> o_DataOut=1, o_Empty=1, o_Count=0 and o_Busy=0 immediately; no further frames after release.
